// File: rtl/lu_ctrl_pkg.sv
// Shared definitions for the logic-unit controller and its function core:
// opcode encodings and the output-stage state type.
package lu_ctrl_pkg;

    localparam int LU_OP_W = 2;

    typedef enum logic [LU_OP_W-1:0] {
        LU_OP_AND = 2'b00,
        LU_OP_OR  = 2'b01,
        LU_OP_XOR = 2'b10,
        LU_OP_NOT = 2'b11
    } lu_op_t;

    // Output register state; FULL means a result is being presented.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/lu_func.sv
// Combinational bitwise logic-function core: g = f(op, a, b).
// NOT uses only operand a.
module lu_func
    import lu_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [LU_OP_W-1:0] op,
    output logic [WIDTH-1:0]   g
);

    // Select the bitwise function; an unknown opcode propagates X in simulation.
    always_comb begin
        g = '0;
        case (op)
            LU_OP_AND: g = a & b;
            LU_OP_OR:  g = a | b;
            LU_OP_XOR: g = a ^ b;
            LU_OP_NOT: g = ~a;
            default:   g = 'x;
        endcase
    end

endmodule

// File: rtl/lu_ctrl.sv
// Command-side controller for the logic unit. Requests are queued in a small
// FIFO, executed one per cycle through lu_func, and returned through a single
// output register with a zero flag. A chained request takes operand A from
// the accumulator, which always holds the most recently executed result.
module lu_ctrl
    import lu_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [LU_OP_W-1:0] req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic               req_chain,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_g,
    output logic               rsp_zero,
    output logic               busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Request storage
    logic [LU_OP_W-1:0] op_mem    [DEPTH];
    logic [WIDTH-1:0]   a_mem     [DEPTH];
    logic [WIDTH-1:0]   b_mem     [DEPTH];
    logic               chain_mem [DEPTH];

    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;

    out_state_t     state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] rsp_g_reg;
    logic           rsp_zero_reg;

    logic           fifo_nonempty;
    logic           fifo_full;
    logic           push;
    logic           exec;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] func_g;

    // Full blocks pushes outright, even when a pop frees a slot the same cycle.
    assign fifo_nonempty = (count_reg != '0);
    assign fifo_full     = (count_reg == FULL_CNT);
    assign push          = req_valid & ~fifo_full;
    assign exec          = fifo_nonempty & ((state_reg == ST_EMPTY) | rsp_ready);

    assign req_ready = ~fifo_full;
    assign rsp_valid = (state_reg == ST_FULL);
    assign rsp_g     = rsp_g_reg;
    assign rsp_zero  = rsp_zero_reg;
    assign busy      = fifo_nonempty | rsp_valid;

    // Head entry feeds the core; chained requests substitute the accumulator.
    assign op_a = chain_mem[rd_ptr_reg] ? acc_reg : a_mem[rd_ptr_reg];

    lu_func #(
        .WIDTH (WIDTH)
    ) u_func (
        .a  (op_a),
        .b  (b_mem[rd_ptr_reg]),
        .op (op_mem[rd_ptr_reg]),
        .g  (func_g)
    );

    // FIFO payload write; contents need no reset since the count gates use.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_reg]    <= req_op;
            a_mem[wr_ptr_reg]     <= req_a;
            b_mem[wr_ptr_reg]     <= req_b;
            chain_mem[wr_ptr_reg] <= req_chain;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (exec) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, exec})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Output-stage FSM with registered result, zero flag and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            acc_reg      <= '0;
            rsp_g_reg    <= '0;
            rsp_zero_reg <= 1'b0;
        end else begin
            if (exec) begin
                state_reg    <= ST_FULL;
                rsp_g_reg    <= func_g;
                rsp_zero_reg <= (func_g == '0);
                acc_reg      <= func_g;
            end else if (rsp_ready) begin
                state_reg    <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_lu_ctrl.sv
// Directed self-checking bench for lu_ctrl (WIDTH=4, DEPTH=2).
module tb_lu_ctrl;
    import lu_ctrl_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_chain;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_g;
    logic             rsp_zero;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    lu_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_g     (rsp_g),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic ch);
        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_chain = ch;
    endtask

    // Single isolated request with rsp_ready=1: accept, no same-cycle output,
    // result one edge later, then drained.
    task automatic do_op(input string name, input logic [1:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic ch, input logic [WIDTH-1:0] exp);
        drive(1'b1, op, a, b, ch);
        chk1({name, "_req_ready"}, req_ready, 1'b1);
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        chk1({name, "_no_bypass"}, rsp_valid, 1'b0);
        tick();
        chk1({name, "_rsp_valid"}, rsp_valid, 1'b1);
        chk4({name, "_rsp_g"}, rsp_g, exp);
        chk1({name, "_rsp_zero"}, rsp_zero, (exp == '0));
        $display("txn %s g=%b zero=%b", name, rsp_g, rsp_zero);
        tick();
        chk1({name, "_drained"}, rsp_valid, 1'b0);
    endtask

    logic [WIDTH-1:0] e;

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b0, 2'b00, '0, '0, 1'b0);

        // Reset state, observed before any clock edge
        #3;
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk4("rst_rsp_g", rsp_g, 4'b0000);
        chk1("rst_rsp_zero", rsp_zero, 1'b0);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic ops, A=1100 B=1010; also shows no same-cycle bypass
        do_op("and", LU_OP_AND, 4'b1100, 4'b1010, 1'b0, 4'b1000);
        do_op("or",  LU_OP_OR,  4'b1100, 4'b1010, 1'b0, 4'b1110);
        do_op("xor", LU_OP_XOR, 4'b1100, 4'b1010, 1'b0, 4'b0110);
        do_op("not", LU_OP_NOT, 4'b1100, 4'b1010, 1'b0, 4'b0011);

        // Chaining through the accumulator (A inputs deliberately junk)
        do_op("ch_and", LU_OP_AND, 4'b1111, 4'b0101, 1'b0, 4'b0101);
        do_op("ch_xor", LU_OP_XOR, 4'b1001, 4'b0101, 1'b1, 4'b0000);
        do_op("ch_not", LU_OP_NOT, 4'b1010, 4'b0000, 1'b1, 4'b1111);

        // Backpressure: R1 stalls in output register, R2/R3 fill the FIFO
        rsp_ready = 1'b0;
        drive(1'b1, LU_OP_OR, 4'b0001, 4'b0010, 1'b0);   // R1 -> 0011
        tick();
        drive(1'b1, LU_OP_AND, 4'b1111, 4'b0110, 1'b0);  // R2 -> 0110
        tick();
        drive(1'b1, LU_OP_XOR, 4'b1010, 4'b0101, 1'b0);  // R3 -> 1111
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        chk1("bp_rsp_valid", rsp_valid, 1'b1);
        chk4("bp_r1_g", rsp_g, 4'b0011);
        chk1("bp_req_ready_full", req_ready, 1'b0);
        chk1("bp_busy", busy, 1'b1);
        tick();
        tick();
        chk4("bp_r1_held", rsp_g, 4'b0011);
        chk1("bp_still_full", req_ready, 1'b0);
        rsp_ready = 1'b1;
        chk1("bp_no_ready_on_pop", req_ready, 1'b0);
        tick();
        chk4("bp_r2_g", rsp_g, 4'b0110);
        chk1("bp_r2_valid", rsp_valid, 1'b1);
        $display("txn bp_r2 g=%b", rsp_g);
        tick();
        chk4("bp_r3_g", rsp_g, 4'b1111);
        chk1("bp_r3_valid", rsp_valid, 1'b1);
        $display("txn bp_r3 g=%b", rsp_g);
        tick();
        chk1("bp_drained", rsp_valid, 1'b0);
        chk4("bp_g_hold_after_drain", rsp_g, 4'b1111);
        chk1("bp_idle", busy, 1'b0);

        // Streaming: 8 back-to-back XOR requests, A=k, B=0011
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) drive(1'b1, LU_OP_XOR, 4'(k), 4'b0011, 1'b0);
            else       drive(1'b0, 2'b00, '0, '0, 1'b0);
            chk1($sformatf("st%0d_req_ready", k), req_ready, 1'b1);
            tick();
            if (k >= 1) begin
                e = 4'(k - 1) ^ 4'b0011;
                chk1($sformatf("st%0d_valid", k - 1), rsp_valid, 1'b1);
                chk4($sformatf("st%0d_g", k - 1), rsp_g, e);
                chk1($sformatf("st%0d_zero", k - 1), rsp_zero, (e == '0));
                $display("txn stream%0d g=%b zero=%b", k - 1, rsp_g, rsp_zero);
            end
        end
        tick();
        chk1("st_drained", rsp_valid, 1'b0);

        // Async reset with FIFO full and a stalled result; acc must clear
        rsp_ready = 1'b0;
        drive(1'b1, LU_OP_OR, 4'b1001, 4'b0000, 1'b0);   // -> 1001, acc=1001
        tick();
        drive(1'b1, LU_OP_AND, 4'b1111, 4'b1111, 1'b0);
        tick();
        drive(1'b1, LU_OP_AND, 4'b1111, 4'b1111, 1'b0);
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        chk1("ar_pre_valid", rsp_valid, 1'b1);
        chk1("ar_pre_full", req_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("ar_rsp_valid", rsp_valid, 1'b0);
        chk1("ar_busy", busy, 1'b0);
        chk1("ar_req_ready", req_ready, 1'b1);
        chk4("ar_rsp_g", rsp_g, 4'b0000);
        tick();
        #2;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        do_op("ar_chain", LU_OP_XOR, 4'b1111, 4'b0110, 1'b1, 4'b0110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
